cu_data_read_engine_multi_stream: RTL and testbench
===================================================

// Module: cu_data_read_engine_multi_stream
// PURPOSE
//  Parametrised read-command engine serving NUM_STREAMS independent array streams.
//  Each stream takes a job (base address, element count) and splits it into cacheline read commands.
//  A round-robin arbiter and a global outstanding-credit limit control issue.
//  Returned responses are counted per stream; each stream pulses done when its job has fully returned.
//  Sits between the WED/job setup logic and the CU read command buffer.
// PARAMETERS
//  NUM_STREAMS      2    independent job streams (>=1); SID_W=max(1,$clog2(NUM_STREAMS))
//  CL_ELEMS         32   elements per 128-byte cacheline; CLE_W=$clog2(CL_ELEMS)+1
//  ELEM_BYTES       4    bytes per element; CL_ELEMS*ELEM_BYTES==128 (elaboration check)
//  SIZE_W           32   width of job element counts
//  MAX_OUTSTANDING  16   max in-flight reads, all streams combined; OST_W=$clog2(MAX_OUTSTANDING)+1
// PORTS
//  clock             in   1               clock, rising edge
//  rstn              in   1               asynchronous active-low reset
//  enabled_in        in   1               gates command issue and job acceptance
//  job_valid_in      in   NUM_STREAMS     per-stream job-start pulse
//  job_addr_in       in   NUM_STREAMS*64  per-stream base byte address
//  job_size_in       in   NUM_STREAMS*SIZE_W  per-stream element count
//  job_mode_in       in   NUM_STREAMS     1=READ_CL_S 128B lines; 0=sized READ_CL_NA/READ_PNA
//  cmd_alfull_in     in   1               read command buffer almost full
//  data_alfull_in    in   1               read data-out buffer almost full
//  cmd_valid_out     out  1               command valid, one cycle per command
//  cmd_addr_out      out  64              command byte address
//  cmd_code_out      out  13              PSL command code
//  cmd_size_out      out  12              command size in bytes
//  cmd_stream_out    out  SID_W           issuing stream id (carried in cmd tag)
//  cmd_real_size_out out  CLE_W           elements carried by the command
//  rsp_valid_in      in   1               read response valid
//  rsp_stream_in     in   SID_W           stream id echoed in response
//  rsp_real_size_in  in   CLE_W           elements completed by the response
//  busy_out          out  NUM_STREAMS     stream not IDLE
//  done_out          out  NUM_STREAMS     one-cycle job-complete pulse
//  done_count_out    out  NUM_STREAMS*SIZE_W  elements returned for current job
//  outstanding_out   out  OST_W           in-flight command count
//  err_out           out  1               sticky: response for IDLE stream, or credit underflow
// BEHAVIOUR
//  Reset: all outputs 0; all streams IDLE; credit counter 0; err_out 0.
//  Per-stream FSM:
//   IDLE  -> ISSUE when job_valid_in[s] && enabled_in; latch addr, size, mode; remaining=size; count=0.
//   IDLE  -> DONE when the accepted size is 0.
//   ISSUE -> DRAIN after the last command is granted (remaining reaches 0).
//   DRAIN -> DONE when count==size.
//   DONE  -> IDLE after one cycle; done_out[s]=1 in DONE only.
//  job_valid_in in a non-IDLE state is ignored.
//  Issue: a stream in ISSUE requests when enabled_in, !cmd_alfull_in, !data_alfull_in and outstanding<MAX_OUTSTANDING.
//   Round-robin grant, lowest index first after reset; pointer advances past the winner; at most 1 grant/cycle.
//   Granted command is registered: cmd_valid_out is high the cycle after the grant.
//  Command fields: n=min(remaining,CL_ELEMS); addr=base+next_off; next_off+=128; real_size=n.
//   mode1: READ_CL_S, size 128.
//   mode0: n==CL_ELEMS gives READ_CL_NA size 128; otherwise READ_PNA with size n*ELEM_BYTES.
//  Credits: +1 on grant and -1 on rsp_valid_in; both in the same cycle leaves the count unchanged.
//   A response at 0 credits sets err_out and leaves the counter at 0.
//  Responses: count[rsp_stream]+=rsp_real_size, registered, 1-cycle latency.
//   A response for an IDLE or DONE stream sets err_out and is dropped.
//  A response and done for the same stream can arrive back to back; count is compared after the update.
//  enabled_in low: no grants and no job acceptance; responses still counted; FSM state held.
//  Address arithmetic is modulo 2^64; wrap is not flagged.
//  Async reset mid-job discards all state; late responses after reset set err_out.
// STRUCTURE
//  CU_PKG: ReadStreamState enum {IDLE,ISSUE,DRAIN,DONE}; READ_CL_S/READ_CL_NA/READ_PNA codes;
//   CACHELINE_SIZE=128; ReadStreamJob struct {addr,size,mode}.
//  Sub-module cu_round_robin_arbiter #(NUM_REQ): req vector in, one-hot grant out, registered pointer.
//  Per-stream state via generate loop; single shared credit counter and output register stage.
// TESTING
//  1 stream, size=70, mode0, addr 0x1000 -> 3 cmds:
//   0x1000 CL_NA/32/128; 0x1080 CL_NA/32/128; 0x1100 PNA/6/24.
//   Responses returned -> done pulse, count=70.
//  Streams 0,1 both size=64, mode1 -> cmds alternate s0,s1,s0,s1, all READ_CL_S size 128.
//   Each stream pulses done after its 2 responses.
//  MAX_OUTSTANDING=4, size=320, no responses -> exactly 4 cmds, outstanding_out=4.
//   One response -> exactly 1 more cmd.
//  Grant and response in the same cycle at outstanding=4 -> stays 4, no overflow.
//   cmd_alfull_in held 10 cycles -> no cmd_valid_out during that window.
//  size=0 job -> done pulse 1 cycle after acceptance, no cmds.
//   Response to IDLE stream -> err_out=1 and stays set.
//  Reset asserted mid-job (2 of 5 cmds issued) -> all outputs 0 immediately.
//   New job after reset -> starts from its base address.

Source files
------------

// File: rtl/cu_data_read_engine_multi_stream_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cu_data_read_engine_multi_stream_pkg                             |
// | Shared types and PSL read command codes for the read engine.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cu_data_read_engine_multi_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } read_stream_state_e;

  localparam logic [12:0] c_READ_CL_S     = 13'h0A50;
  localparam logic [12:0] c_READ_CL_NA    = 13'h0A00;
  localparam logic [12:0] c_READ_PNA      = 13'h0E00;
  localparam int          c_CACHELINE_SIZE = 128;

  // Size held at full 64-bit width so one struct serves any SIZE_W.
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] size;
    logic        mode;
  } read_stream_job_t;

  function automatic logic [12:0] cmd_code(input logic mode, input logic full_line);
    if (mode)           return c_READ_CL_S;
    else if (full_line) return c_READ_CL_NA;
    else                return c_READ_PNA;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cu_data_read_engine_multi_stream_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cu_data_read_engine_multi_stream_arbiter                         |
// | Round-robin arbiter: one-hot grant, pointer moves past winner.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cu_data_read_engine_multi_stream_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] w_idx;
  logic [c_PTR_W-1:0] w_win;
  logic               w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = c_PTR_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    if (w_found) o_grant[w_win] = 1'b1;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_win == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_win + c_PTR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cu_data_read_engine_multi_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cu_data_read_engine_multi_stream                                 |
// | Splits per-stream jobs into cacheline reads under a credit cap.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cu_data_read_engine_multi_stream
  import cu_data_read_engine_multi_stream_pkg::*;
#(
  parameter  int NUM_STREAMS     = 2,
  parameter  int CL_ELEMS        = 32,
  parameter  int ELEM_BYTES      = 4,
  parameter  int SIZE_W          = 32,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int SID_W           = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1,
  localparam int CLE_W           = $clog2(CL_ELEMS) + 1,
  localparam int OST_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                          clock,
  input  logic                          rstn,
  input  logic                          enabled_in,
  input  logic [NUM_STREAMS-1:0]        job_valid_in,
  input  logic [NUM_STREAMS*64-1:0]     job_addr_in,
  input  logic [NUM_STREAMS*SIZE_W-1:0] job_size_in,
  input  logic [NUM_STREAMS-1:0]        job_mode_in,
  input  logic                          cmd_alfull_in,
  input  logic                          data_alfull_in,
  output logic                          cmd_valid_out,
  output logic [63:0]                   cmd_addr_out,
  output logic [12:0]                   cmd_code_out,
  output logic [11:0]                   cmd_size_out,
  output logic [SID_W-1:0]              cmd_stream_out,
  output logic [CLE_W-1:0]              cmd_real_size_out,
  input  logic                          rsp_valid_in,
  input  logic [SID_W-1:0]              rsp_stream_in,
  input  logic [CLE_W-1:0]              rsp_real_size_in,
  output logic [NUM_STREAMS-1:0]        busy_out,
  output logic [NUM_STREAMS-1:0]        done_out,
  output logic [NUM_STREAMS*SIZE_W-1:0] done_count_out,
  output logic [OST_W-1:0]              outstanding_out,
  output logic                          err_out
);

  if (CL_ELEMS * ELEM_BYTES != c_CACHELINE_SIZE) begin : g_bad_geometry
    $error("CL_ELEMS*ELEM_BYTES must equal one 128-byte cacheline");
  end

  logic [NUM_STREAMS-1:0] w_req;
  logic [NUM_STREAMS-1:0] w_grant;
  logic [NUM_STREAMS-1:0] w_rsp_hit;
  logic [63:0]            w_addr_arr [NUM_STREAMS];
  logic [CLE_W-1:0]       w_n_arr    [NUM_STREAMS];
  logic                   w_mode_arr [NUM_STREAMS];
  logic [OST_W-1:0]       r_ost;
  logic                   r_err;
  logic                   w_issue_ok;
  logic                   w_inc;

  assign w_issue_ok = enabled_in && !cmd_alfull_in && !data_alfull_in &&
                      (r_ost < OST_W'(MAX_OUTSTANDING));
  assign w_inc      = |w_grant;

  for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_stream
    read_stream_state_e r_state;
    read_stream_job_t   r_job;
    logic [SIZE_W-1:0]  r_remaining;
    logic [63:0]        r_next_off;
    logic [SIZE_W-1:0]  r_count;
    logic [CLE_W-1:0]   w_n;

    assign w_n = (r_remaining < SIZE_W'(CL_ELEMS)) ? r_remaining[CLE_W-1:0]
                                                   : CLE_W'(CL_ELEMS);
    assign w_req[s]      = (r_state == ISSUE) && w_issue_ok;
    assign w_rsp_hit[s]  = rsp_valid_in && (rsp_stream_in == SID_W'(s)) &&
                           ((r_state == ISSUE) || (r_state == DRAIN));
    assign w_addr_arr[s] = r_job.addr + r_next_off;
    assign w_n_arr[s]    = w_n;
    assign w_mode_arr[s] = r_job.mode;

    assign busy_out[s]                         = (r_state != IDLE);
    assign done_out[s]                         = (r_state == DONE);
    assign done_count_out[s*SIZE_W +: SIZE_W]  = r_count;

    always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
        r_state     <= IDLE;
        r_job       <= '0;
        r_remaining <= '0;
        r_next_off  <= '0;
        r_count     <= '0;
      end else begin
        if (w_rsp_hit[s]) r_count <= r_count + SIZE_W'(rsp_real_size_in);
        // Transitions freeze while disabled; response counting above does not.
        if (enabled_in) begin
          case (r_state)
            IDLE: begin
              if (job_valid_in[s]) begin
                r_job.addr  <= job_addr_in[s*64 +: 64];
                r_job.size  <= 64'(job_size_in[s*SIZE_W +: SIZE_W]);
                r_job.mode  <= job_mode_in[s];
                r_remaining <= job_size_in[s*SIZE_W +: SIZE_W];
                r_next_off  <= '0;
                r_count     <= '0;
                r_state     <= (job_size_in[s*SIZE_W +: SIZE_W] == '0) ? DONE : ISSUE;
              end
            end
            ISSUE: begin
              if (w_grant[s]) begin
                r_remaining <= r_remaining - SIZE_W'(w_n);
                r_next_off  <= r_next_off + 64'(c_CACHELINE_SIZE);
                if (r_remaining == SIZE_W'(w_n)) r_state <= DRAIN;
              end
            end
            DRAIN: begin
              if (64'(r_count) == r_job.size) r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  cu_data_read_engine_multi_stream_arbiter #(
    .NUM_REQ (NUM_STREAMS)
  ) u_arbiter (
    .clock   (clock),
    .rstn    (rstn),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  logic [SID_W-1:0] w_sel;
  logic [CLE_W-1:0] w_sel_n;
  logic             w_sel_full;
  logic             w_sel_mode;

  always_comb begin
    w_sel = '0;
    for (int s = 0; s < NUM_STREAMS; s++) begin
      if (w_grant[s]) w_sel = SID_W'(s);
    end
  end

  assign w_sel_n    = w_n_arr[w_sel];
  assign w_sel_mode = w_mode_arr[w_sel];
  assign w_sel_full = (w_sel_n == CLE_W'(CL_ELEMS));

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cmd_valid_out     <= 1'b0;
      cmd_addr_out      <= '0;
      cmd_code_out      <= '0;
      cmd_size_out      <= '0;
      cmd_stream_out    <= '0;
      cmd_real_size_out <= '0;
    end else begin
      cmd_valid_out <= w_inc;
      if (w_inc) begin
        cmd_addr_out      <= w_addr_arr[w_sel];
        cmd_code_out      <= cmd_code(w_sel_mode, w_sel_full);
        cmd_size_out      <= (w_sel_mode || w_sel_full) ? 12'(c_CACHELINE_SIZE)
                                                        : 12'(32'(w_sel_n) * ELEM_BYTES);
        cmd_stream_out    <= w_sel;
        cmd_real_size_out <= w_sel_n;
      end
    end
  end

  // A response with no credit outstanding is ignored for counting but flagged.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_ost <= '0;
      r_err <= 1'b0;
    end else begin
      if (rsp_valid_in && ((r_ost == '0) || !(|w_rsp_hit))) r_err <= 1'b1;
      if (w_inc && (!rsp_valid_in || (r_ost == '0))) r_ost <= r_ost + OST_W'(1);
      else if (!w_inc && rsp_valid_in && (r_ost != '0)) r_ost <= r_ost - OST_W'(1);
    end
  end

  assign outstanding_out = r_ost;
  assign err_out         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cu_data_read_engine_multi_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cu_data_read_engine_multi_stream                              |
// | Random and directed stimulus against a queue-based command model.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_cu_data_read_engine_multi_stream;

  localparam int NS   = 2;
  localparam int MAXO = 4;

  logic          clock = 1'b0;
  logic          rstn = 1'b0;
  logic          enabled_in = 1'b0;
  logic [1:0]    job_valid_in = '0;
  logic [127:0]  job_addr_in = '0;
  logic [63:0]   job_size_in = '0;
  logic [1:0]    job_mode_in = '0;
  logic          cmd_alfull_in = 1'b0;
  logic          data_alfull_in = 1'b0;
  logic          cmd_valid_out;
  logic [63:0]   cmd_addr_out;
  logic [12:0]   cmd_code_out;
  logic [11:0]   cmd_size_out;
  logic [0:0]    cmd_stream_out;
  logic [5:0]    cmd_real_size_out;
  logic          rsp_valid_in = 1'b0;
  logic [0:0]    rsp_stream_in = '0;
  logic [5:0]    rsp_real_size_in = '0;
  logic [1:0]    busy_out;
  logic [1:0]    done_out;
  logic [63:0]   done_count_out;
  logic [2:0]    outstanding_out;
  logic          err_out;

  cu_data_read_engine_multi_stream #(
    .NUM_STREAMS(NS), .CL_ELEMS(32), .ELEM_BYTES(4), .SIZE_W(32), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .job_valid_in(job_valid_in), .job_addr_in(job_addr_in), .job_size_in(job_size_in),
    .job_mode_in(job_mode_in), .cmd_alfull_in(cmd_alfull_in), .data_alfull_in(data_alfull_in),
    .cmd_valid_out(cmd_valid_out), .cmd_addr_out(cmd_addr_out), .cmd_code_out(cmd_code_out),
    .cmd_size_out(cmd_size_out), .cmd_stream_out(cmd_stream_out),
    .cmd_real_size_out(cmd_real_size_out), .rsp_valid_in(rsp_valid_in),
    .rsp_stream_in(rsp_stream_in), .rsp_real_size_in(rsp_real_size_in),
    .busy_out(busy_out), .done_out(done_out), .done_count_out(done_count_out),
    .outstanding_out(outstanding_out), .err_out(err_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] addr;
    logic [12:0] code;
    logic [11:0] size;
    logic [5:0]  rs;
  } cmd_t;

  typedef struct packed {
    logic       sid;
    logic [5:0] rs;
  } inf_t;

  cmd_t        exp_q [NS][$];
  inf_t        infl[$];
  int          cmd_order[$];
  int          cmd_total, rsp_total;
  int          pending [NS];
  logic [31:0] job_size_m [NS];
  bit          active [NS];
  bit          exp_err;
  int          n_checks, n_fail;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < NS; s++) begin
      exp_q[s].delete();
      pending[s] = 0;
      active[s]  = 1'b0;
    end
    infl.delete();
    cmd_order.delete();
    cmd_total = 0;
    rsp_total = 0;
    exp_err   = 1'b0;
  endtask

  // Expected command list: cachelines of up to 32 elements from the base upward.
  task automatic start_job(input int s, input logic [63:0] base, input logic [31:0] size,
                           input bit mode);
    logic [31:0] rem;
    logic [63:0] off;
    int          n;
    cmd_t        c;
    job_valid_in[s]          = 1'b1;
    job_addr_in[s*64 +: 64]  = base;
    job_size_in[s*32 +: 32]  = size;
    job_mode_in[s]           = mode;
    active[s]     = 1'b1;
    job_size_m[s] = size;
    rem = size;
    off = '0;
    while (rem > 0) begin
      n      = (rem < 32) ? int'(rem) : 32;
      c.addr = base + off;
      c.rs   = 6'(n);
      if (mode)         begin c.code = 13'h0A50; c.size = 12'd128; end
      else if (n == 32) begin c.code = 13'h0A00; c.size = 12'd128; end
      else              begin c.code = 13'h0E00; c.size = 12'(n * 4); end
      exp_q[s].push_back(c);
      rem = rem - 32'(n);
      off = off + 64'd128;
    end
  endtask

  task automatic send_rsp(input int idx);
    inf_t e;
    e = infl[idx];
    infl.delete(idx);
    rsp_valid_in     = 1'b1;
    rsp_stream_in    = e.sid;
    rsp_real_size_in = e.rs;
    pending[e.sid]--;
    rsp_total++;
  endtask

  task automatic step();
    cmd_t c;
    inf_t f;
    int   s;
    @(posedge clock);
    #1;
    if (cmd_valid_out) begin
      s = int'(cmd_stream_out);
      cmd_order.push_back(s);
      cmd_total++;
      if (exp_q[s].size() == 0) begin
        check("cmd_unexpected", 1, 0);
      end else begin
        c = exp_q[s].pop_front();
        check("cmd", {cmd_addr_out, cmd_code_out, cmd_size_out, cmd_real_size_out}, c);
        f = {cmd_stream_out, cmd_real_size_out};
        infl.push_back(f);
        pending[s]++;
      end
    end
    check("outstanding", outstanding_out, cmd_total - rsp_total);
    check("err", err_out, exp_err);
    for (int k = 0; k < NS; k++) begin
      if (done_out[k]) begin
        if (!active[k]) begin
          check("done_spurious", 1, 0);
        end else begin
          check("done_count", done_count_out[k*32 +: 32], job_size_m[k]);
          check("done_left", exp_q[k].size() + pending[k], 0);
          active[k] = 1'b0;
        end
      end else begin
        check("busy", busy_out[k], active[k]);
      end
    end
    job_valid_in = '0;
    rsp_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    job_valid_in  = '0;
    rsp_valid_in  = 1'b0;
    cmd_alfull_in = 1'b0;
    data_alfull_in = 1'b0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain(input int max);
    int c;
    c = 0;
    while ((active[0] || active[1] || infl.size() > 0) && c < max) begin
      if (infl.size() > 0) send_rsp($urandom_range(0, infl.size() - 1));
      step();
      c++;
    end
    check("drain_timeout", c < max, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          base_cnt;
    logic [3:0]  ord;
    logic [63:0] a;
    logic [31:0] sz;
    n_checks = 0;
    n_fail   = 0;
    clear_model();

    // Reset values
    #12;
    check("rst_ctrl", {cmd_valid_out, busy_out, done_out, outstanding_out, err_out}, 0);
    check("rst_count", done_count_out, 0);
    @(posedge clock);
    #1;
    rstn       = 1'b1;
    enabled_in = 1'b1;

    // 70 elements, sized mode: two full lines and a 6-element partial
    start_job(0, 64'h1000, 70, 1'b0);
    repeat (10) step();
    check("t70_cmds", cmd_total, 3);
    drain(200);

    // Two streams in line mode alternate from stream 0 after reset
    do_reset();
    start_job(0, 64'h4000, 64, 1'b1);
    start_job(1, 64'h8000, 64, 1'b1);
    repeat (8) step();
    check("rr_count", cmd_order.size(), 4);
    ord = '0;
    for (int i = 0; i < 4 && i < cmd_order.size(); i++) ord[i] = cmd_order[i][0];
    check("rr_order", ord, 4'b1010);
    drain(200);

    // Credit ceiling with no responses, then one response frees one slot
    start_job(0, 64'h2000_0000, 320, 1'b0);
    base_cnt = cmd_total;
    repeat (12) step();
    check("credit_cmds", cmd_total - base_cnt, MAXO);
    check("credit_ost", outstanding_out, MAXO);
    send_rsp(0);
    repeat (6) step();
    check("credit_one_more", cmd_total - base_cnt, MAXO + 1);
    cmd_alfull_in = 1'b1;
    base_cnt = cmd_total;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) send_rsp(0);
      step();
    end
    check("alfull_block", cmd_total - base_cnt, 0);
    cmd_alfull_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (infl.size() > 0) send_rsp(0);
      step();
      check("ost_max", outstanding_out <= 3'(MAXO), 1);
    end
    drain(300);

    // Zero-length job completes one cycle after acceptance
    base_cnt = cmd_total;
    start_job(1, 64'h5000, 0, 1'b0);
    step();
    check("zero_done", done_out[1], 1'b1);
    step();
    check("zero_idle", busy_out[1], 1'b0);
    check("zero_cmds", cmd_total - base_cnt, 0);

    // Disabled engine refuses jobs
    enabled_in = 1'b0;
    job_valid_in[0] = 1'b1;
    job_size_in[31:0] = 32'd5;
    step();
    step();
    check("disabled_ignore", busy_out[0], 1'b0);
    enabled_in = 1'b1;

    // Response to an idle stream latches the error flag
    rsp_valid_in     = 1'b1;
    rsp_stream_in    = 1'b1;
    rsp_real_size_in = 6'd1;
    exp_err = 1'b1;
    repeat (5) step();

    // Asynchronous reset two commands into a five-command job
    do_reset();
    start_job(0, 64'h7000, 160, 1'b0);
    for (int i = 0; i < 20 && cmd_total < 2; i++) step();
    check("mid_issued", cmd_total, 2);
    rstn = 1'b0;
    #1;
    check("async_rst_ctrl", {cmd_valid_out, busy_out, done_out, outstanding_out, err_out}, 0);
    check("async_rst_count", done_count_out, 0);
    clear_model();
    @(posedge clock);
    #1;
    rstn = 1'b1;
    rsp_valid_in     = 1'b1;
    rsp_stream_in    = 1'b0;
    rsp_real_size_in = 6'd32;
    exp_err = 1'b1;
    step();
    do_reset();
    start_job(0, 64'h9000, 40, 1'b0);
    drain(200);

    // Randomized traffic including wraparound bases and odd lengths
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int s = 0; s < NS; s++) begin
        if (!active[s] && !busy_out[s] && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
          else                           a = {$urandom(), $urandom()};
          case ($urandom_range(0, 4))
            0:       sz = 32'd0;
            1:       sz = 32'd32;
            2:       sz = 32'd33;
            3:       sz = 32'($urandom_range(1, 31));
            default: sz = 32'($urandom_range(1, 200));
          endcase
          start_job(s, a, sz, 1'($urandom_range(0, 1)));
        end
      end
      cmd_alfull_in  = ($urandom_range(0, 7) == 0);
      data_alfull_in = ($urandom_range(0, 7) == 0);
      if (infl.size() > 0 && $urandom_range(0, 1) == 1) send_rsp($urandom_range(0, infl.size() - 1));
      step();
    end
    cmd_alfull_in  = 1'b0;
    data_alfull_in = 1'b0;
    drain(2000);
    check("final_ost", outstanding_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
